// File: rtl/rx_lane_scheduler.sv
// rx_lane_scheduler
// Distributes a ready/valid byte stream round-robin over 1, 2 or 4 lanes and
// presents each completed group with per-lane valids. A group that stops
// filling for FLUSH_TIMEOUT idle cycles is presented partially filled.
//
// Optional build macro: SCHED_STATS_EN
//   When defined, adds grp_count (retired groups) and flush_count (retired
//   timeout-flushed groups) outputs. Both are 16-bit wrapping counters.
module rx_lane_scheduler #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned FLUSH_TIMEOUT = 15   // 1..255
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cfg_lanes,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  input  logic              out_ready,
  output logic              busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]       grp_count,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(FLUSH_TIMEOUT);

  // Lane count as a plain number (1, 2 or 4); the reserved code 11 means x4.
  function automatic logic [2:0] decode_lanes(input logic [1:0] cfg);
    case (cfg)
      2'b00:   decode_lanes = 3'd1;
      2'b01:   decode_lanes = 3'd2;
      default: decode_lanes = 3'd4;
    endcase
  endfunction

  // Valid mask covering the lowest 'count' slots.
  function automatic logic [3:0] fill_mask(input logic [2:0] count);
    case (count)
      3'd1:    fill_mask = 4'b0001;
      3'd2:    fill_mask = 4'b0011;
      3'd3:    fill_mask = 4'b0111;
      3'd4:    fill_mask = 4'b1111;
      default: fill_mask = 4'b0000;
    endcase
  endfunction

  state_e            state_q,   state_d;
  logic [1:0]        ptr_q,     ptr_d;
  logic [7:0]        idle_q,    idle_d;
  logic [2:0]        lanes_q,   lanes_d;
  logic [3:0]        valid_q,   valid_d;
  logic              flushed_q, flushed_d;
  logic [DATA_W-1:0] slot_q [4];
  logic [DATA_W-1:0] slot_d [4];

  logic              accept;
  logic              retire;
  logic              start_grp;
  logic [2:0]        new_lanes;
  logic [7:0]        idle_inc;

  assign new_lanes = decode_lanes(cfg_lanes);
  // Saturating increment: a long stall never wraps back below the timeout.
  assign idle_inc  = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  // Next-state, slot writes and handshake for the IDLE/FILL/HOLD sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    idle_d    = idle_q;
    lanes_d   = lanes_q;
    valid_d   = valid_q;
    flushed_d = flushed_q;
    slot_d    = slot_q;
    in_ready  = 1'b1;
    accept    = 1'b0;
    retire    = 1'b0;
    start_grp = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        start_grp = in_valid;
      end

      S_FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          slot_d[ptr_q] = in_data;
          idle_d        = 8'd0;
          if ({1'b0, ptr_q} == lanes_q - 3'd1) begin
            state_d   = S_HOLD;
            valid_d   = fill_mask(lanes_q);
            flushed_d = 1'b0;
            ptr_d     = 2'd0;
          end else begin
            ptr_d = ptr_q + 2'd1;
          end
        end else begin
          idle_d = idle_inc;
          if (idle_inc >= TIMEOUT) begin
            // Partial group: only the slots written so far are presented.
            state_d   = S_HOLD;
            valid_d   = fill_mask({1'b0, ptr_q});
            flushed_d = 1'b1;
            idle_d    = 8'd0;
            ptr_d     = 2'd0;
          end
        end
      end

      S_HOLD: begin
        // Accept a new byte only in the cycle the held group retires.
        in_ready = out_ready;
        accept   = in_valid && out_ready;
        if (out_ready) begin
          retire = 1'b1;
          if (in_valid) begin
            start_grp = 1'b1;
          end else begin
            state_d   = S_IDLE;
            valid_d   = 4'b0000;
            flushed_d = 1'b0;
            ptr_d     = 2'd0;
            idle_d    = 8'd0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 4'b0000;
        ptr_d   = 2'd0;
        idle_d  = 8'd0;
      end
    endcase

    // First byte of a group: lands in slot 0 and re-latches the lane count.
    if (start_grp) begin
      slot_d[0] = in_data;
      lanes_d   = new_lanes;
      idle_d    = 8'd0;
      flushed_d = 1'b0;
      if (new_lanes == 3'd1) begin
        state_d = S_HOLD;
        valid_d = 4'b0001;
        ptr_d   = 2'd0;
      end else begin
        state_d = S_FILL;
        valid_d = 4'b0000;
        ptr_d   = 2'd1;
      end
    end
  end

  // State, pointer, counters and lane registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      idle_q    <= 8'd0;
      lanes_q   <= 3'd4;
      valid_q   <= 4'b0000;
      flushed_q <= 1'b0;
      // NOTE: the slot array drives out_data directly, so it is reset like
      // any other register; outputs must read zero while reset is held.
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of the others.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idle_q    <= idle_d;
      lanes_q   <= lanes_d;
      valid_q   <= valid_d;
      flushed_q <= flushed_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign out_data0  = slot_q[0];
  assign out_data1  = slot_q[1];
  assign out_data2  = slot_q[2];
  assign out_data3  = slot_q[3];
  assign out_valid0 = valid_q[0];
  assign out_valid1 = valid_q[1];
  assign out_valid2 = valid_q[2];
  assign out_valid3 = valid_q[3];
  assign busy       = (state_q != S_IDLE);

`ifdef SCHED_STATS_EN
  logic [15:0] grp_cnt_q;
  logic [15:0] flush_cnt_q;

  // Retirement statistics; both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grp_cnt_q   <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else if (retire) begin
      grp_cnt_q <= grp_cnt_q + 16'd1;
      if (flushed_q) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign grp_count   = grp_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
